// File: rtl/fifo_stim_pkg.sv
// Shared types and constants for the FIFO write-side stimulus generator.
package fifo_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } stim_state_e;

  localparam int unsigned MODE_INC  = 0;
  localparam int unsigned MODE_LFSR = 1;

  // Right-shift Galois masks: bit (k-1) set for each x^k term of the polynomial.
  function automatic logic [31:0] lfsr_taps(input int unsigned dw);
    case (dw)
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/stim_data_gen.sv
// Data pattern register: incrementing count or maximal-length Galois LFSR.
module stim_data_gen
  import fifo_stim_pkg::*;
#(
  parameter int unsigned    DW   = 8,
  parameter int unsigned    MODE = MODE_INC,
  parameter logic [DW-1:0]  SEED = {{(DW-1){1'b0}}, 1'b1}
) (
  input  logic          clka,
  input  logic          rstna,
  input  logic          load_seed,
  input  logic          advance,
  output logic [DW-1:0] data
);

  localparam logic [31:0]   TAPS_FULL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS      = TAPS_FULL[DW-1:0];

  logic [DW-1:0] next_data;

  always_comb begin
    next_data = data + DW'(1);
    if (MODE == MODE_LFSR)
      next_data = (data >> 1) ^ (data[0] ? TAPS : '0);
  end

  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna)
      data <= '0;
    else if (load_seed)
      data <= SEED;
    else if (advance)
      data <= next_data;
  end

endmodule

// File: rtl/fifo_wr_stim_gen.sv
// Write-side stimulus generator: bursts of accepted writes separated by idle gaps.
module fifo_wr_stim_gen
  import fifo_stim_pkg::*;
#(
  parameter int unsigned   DW         = 8,
  parameter int unsigned   BURST_LEN  = 512,
  parameter int unsigned   NUM_BURSTS = 4,
  parameter int unsigned   GAP_CYCLES = 2,
  parameter int unsigned   MODE       = MODE_INC,
  parameter logic [DW-1:0] SEED       = {{(DW-1){1'b0}}, 1'b1},
  parameter int unsigned   CW         = 16
) (
  input  logic          clka,
  input  logic          rstna,
  input  logic          start,
  input  logic          hold,
  input  logic          fulla,
  output logic          wreqa,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] wr_count
);

  localparam int unsigned BW  = $clog2(BURST_LEN + 1);
  localparam int unsigned NBW = $clog2(NUM_BURSTS + 1);
  localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

  stim_state_e    state;
  logic [BW-1:0]  beat_cnt;
  logic [NBW-1:0] burst_cnt;
  logic [GW-1:0]  gap_cnt;

  logic launch;
  logic accept;
  logic last_beat;
  logic last_burst;

  assign launch     = start && (state == IDLE || state == DONE);
  assign accept     = (state == BURST) && wreqa && !fulla;
  assign last_beat  = (beat_cnt == BW'(BURST_LEN - 1));
  assign last_burst = (burst_cnt == NBW'(NUM_BURSTS - 1));

  stim_data_gen #(
    .DW   (DW),
    .MODE (MODE),
    .SEED (SEED)
  ) u_data (
    .clka      (clka),
    .rstna     (rstna),
    .load_seed (launch),
    .advance   (accept),
    .data      (wdata)
  );

  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      state     <= IDLE;
      wreqa     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= BURST;
            wreqa     <= ~hold;
            busy      <= 1'b1;
            done      <= 1'b0;
            wr_count  <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
          end
        end
        BURST: begin
          // A stalled or held word keeps its data; only an accept moves on.
          wreqa <= ~hold;
          if (accept) begin
            wr_count <= wr_count + CW'(1);
            if (last_beat) begin
              wreqa    <= 1'b0;
              beat_cnt <= '0;
              if (last_burst) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= GAP;
                gap_cnt   <= GW'(GAP_CYCLES - 1);
                burst_cnt <= burst_cnt + NBW'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        GAP: begin
          wreqa <= 1'b0;
          if (gap_cnt == '0) begin
            state <= BURST;
            wreqa <= ~hold;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_stim_gen.sv
// Directed bench for fifo_wr_stim_gen: three configurations share clock and reset.
module tb_fifo_wr_stim_gen;

  logic clka = 1'b0;
  logic rstna;

  always #5 clka = ~clka;

  logic        start0, hold0, full0, wreq0, busy0, done0;
  logic [7:0]  wdata0;
  logic [15:0] cnt0;
  logic        start1, hold1, full1, wreq1, busy1, done1;
  logic [7:0]  wdata1;
  logic [15:0] cnt1;
  logic        start2, hold2, full2, wreq2, busy2, done2;
  logic [7:0]  wdata2;
  logic [15:0] cnt2;

  fifo_wr_stim_gen #(
    .DW(8), .BURST_LEN(4), .NUM_BURSTS(2), .GAP_CYCLES(2),
    .MODE(0), .SEED(8'h01), .CW(16)
  ) u0 (
    .clka(clka), .rstna(rstna), .start(start0), .hold(hold0), .fulla(full0),
    .wreqa(wreq0), .wdata(wdata0), .busy(busy0), .done(done0), .wr_count(cnt0)
  );

  fifo_wr_stim_gen #(
    .DW(8), .BURST_LEN(4), .NUM_BURSTS(1), .GAP_CYCLES(2),
    .MODE(0), .SEED(8'hFE), .CW(16)
  ) u1 (
    .clka(clka), .rstna(rstna), .start(start1), .hold(hold1), .fulla(full1),
    .wreqa(wreq1), .wdata(wdata1), .busy(busy1), .done(done1), .wr_count(cnt1)
  );

  fifo_wr_stim_gen #(
    .DW(8), .BURST_LEN(255), .NUM_BURSTS(1), .GAP_CYCLES(2),
    .MODE(1), .SEED(8'h01), .CW(16)
  ) u2 (
    .clka(clka), .rstna(rstna), .start(start2), .hold(hold2), .fulla(full2),
    .wreqa(wreq2), .wdata(wdata2), .busy(busy2), .done(done2), .wr_count(cnt2)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  logic [7:0]   m;
  logic [255:0] seen;

  initial begin
    rstna  = 1'b0;
    start0 = 1'b0; hold0 = 1'b0; full0 = 1'b0;
    start1 = 1'b0; hold1 = 1'b0; full1 = 1'b0;
    start2 = 1'b0; hold2 = 1'b0; full2 = 1'b0;
    #12;
    chk("rst_wreqa", wreq0, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_count", cnt0, 0);
    rstna = 1'b1;
    tick();
    tick();
    chk("idle_no_wreq", wreq0, 0);

    // Basic two-burst run with gap
    start0 = 1'b1; tick(); start0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("b1_wreqa", wreq0, 1);
      chk("b1_wdata", wdata0, i);
      tick();
    end
    chk("gap1_wreqa", wreq0, 0);
    chk("gap_busy", busy0, 1);
    tick();
    chk("gap2_wreqa", wreq0, 0);
    tick();
    for (int i = 5; i <= 8; i++) begin
      chk("b2_wreqa", wreq0, 1);
      chk("b2_wdata", wdata0, i);
      tick();
    end
    chk("t1_done", done0, 1);
    chk("t1_busy", busy0, 0);
    chk("t1_count", cnt0, 8);
    chk("t1_wreqa", wreq0, 0);

    // fulla stall mid-burst, restart from DONE
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t2_done_drop", done0, 0);
    chk("t2_busy", busy0, 1);
    chk("t2_count0", cnt0, 0);
    chk("t2_seed", wdata0, 1);
    tick(); tick();
    chk("t2_pre_stall", wdata0, 3);
    full0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wreqa", wreq0, 1);
      chk("stall_wdata", wdata0, 3);
      chk("stall_count", cnt0, 2);
    end
    full0 = 1'b0;
    tick();
    chk("resume_wdata", wdata0, 4);
    tick();
    chk("t2_gap_wreqa", wreq0, 0);
    chk("t2_mid_count", cnt0, 4);
    tick(); tick();
    for (int i = 5; i <= 8; i++) begin
      chk("t2_b2_wreqa", wreq0, 1);
      chk("t2_b2_wdata", wdata0, i);
      tick();
    end
    chk("t2_done", done0, 1);
    chk("t2_count", cnt0, 8);

    // hold mid-burst, then start-while-busy and async reset in burst 2
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick();
    chk("t5_pre_hold", wdata0, 2);
    hold0 = 1'b1;
    tick();
    chk("hold_wreqa", wreq0, 0);
    chk("hold_wdata", wdata0, 3);
    chk("hold_count", cnt0, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_wreqa", wreq0, 0);
      chk("held_wdata", wdata0, 3);
      chk("held_count", cnt0, 2);
    end
    hold0 = 1'b0;
    tick();
    chk("unhold_wreqa", wreq0, 1);
    chk("unhold_wdata", wdata0, 3);
    tick();
    chk("unhold_next", wdata0, 4);
    chk("unhold_count", cnt0, 3);
    tick(); tick(); tick();
    chk("t5_b2_wreqa", wreq0, 1);
    chk("t5_b2_wdata", wdata0, 5);
    tick();
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("busy_start_wdata", wdata0, 7);
    chk("busy_start_count", cnt0, 6);
    chk("busy_start_busy", busy0, 1);
    rstna = 1'b0;
    #1;
    chk("arst_wreqa", wreq0, 0);
    chk("arst_wdata", wdata0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    chk("arst_count", cnt0, 0);
    #3;
    rstna = 1'b1;
    tick(); tick();
    chk("post_rst_wreqa", wreq0, 0);
    chk("post_rst_busy", busy0, 0);
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("replay_wreqa", wreq0, 1);
    chk("replay_wdata", wdata0, 1);
    chk("replay_count", cnt0, 0);
    tick();
    chk("replay_next", wdata0, 2);
    chk("replay_count1", cnt0, 1);

    // Wrap at 2^DW, with fulla on the final beat
    start1 = 1'b1; tick(); start1 = 1'b0;
    m = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_wreqa", wreq1, 1);
      chk("wrap_wdata", wdata1, m);
      m = m + 8'd1;
      tick();
    end
    chk("last_wdata", wdata1, 8'h01);
    full1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("last_stall_wreqa", wreq1, 1);
      chk("last_stall_wdata", wdata1, 8'h01);
      chk("last_stall_busy", busy1, 1);
      chk("last_stall_done", done1, 0);
    end
    full1 = 1'b0;
    tick();
    chk("t3_done", done1, 1);
    chk("t3_busy", busy1, 0);
    chk("t3_count", cnt1, 4);
    chk("t3_wreqa", wreq1, 0);

    // LFSR full period
    seen = '0;
    m = 8'h01;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 255; i++) begin
      chk("lfsr_wreqa", wreq2, 1);
      chk("lfsr_nonzero", (wdata2 != 8'h00), 1);
      chk("lfsr_unique", seen[wdata2], 0);
      seen[wdata2] = 1'b1;
      chk("lfsr_wdata", wdata2, m);
      m = {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00);
      tick();
    end
    chk("t4_done", done2, 1);
    chk("t4_count", cnt2, 255);
    chk("t4_wrap_seed", wdata2, 8'h01);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_stim_gen.md
Name: fifo_wr_stim_gen

Overview:
Parametrised write-side stimulus generator for the async FIFO benches, driving the write port in the clka domain. Issues NUM_BURSTS bursts of BURST_LEN accepted writes with programmable idle gaps. Data comes from one of two patterns: incrementing or LFSR. It honours fulla back-pressure, supports a pause input, and reports completion and the accepted-write count for scoreboarding.

Parameters:
DW, 8, data width; legal values 8, 16, 32
BURST_LEN, 512, accepted writes per burst; at least 1
NUM_BURSTS, 4, bursts per run; at least 1
GAP_CYCLES, 2, idle cycles between bursts with wreqa=0; at least 1
MODE, 0, data pattern: 0 = incrementing, 1 = LFSR
SEED, 1, first data word of a run; nonzero when MODE=1
CW, 16, width of wr_count

Ports:
clka  in  1  write-domain clock
rstna  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run from IDLE or DONE, ignored otherwise
hold  in  1  pause request; while 1, wreqa is deasserted on the next edge
fulla  in  1  FIFO full flag, already synchronous to clka
wreqa  out  1  write request, registered
wdata  out  DW  write data, registered
busy  out  1  high in BURST and GAP
done  out  1  high in DONE until the next start
wr_count  out  CW  accepted writes in the current run; wraps modulo 2^CW

Behaviour:
- Reset values: wreqa=0, wdata=0, busy=0, done=0, wr_count=0, state=IDLE, beat and burst counters 0.
- Accept rule: a write is accepted at a rising edge when wreqa=1 and fulla=0. Only accepts advance wdata, the beat counter and wr_count.
- fulla=1 with wreqa=1: wreqa stays 1 and wdata stays stable. No write is lost or duplicated.
- States: IDLE, BURST, GAP, DONE.
- IDLE, start=1: next edge goes to BURST, with wreqa=~hold, wdata=SEED, counters cleared, wr_count=0.
- DONE, start=1: same as IDLE. done drops on that edge.
- BURST:
  - wreqa(next) = ~hold.
  - A pending unaccepted word is retained across hold.
  - On the accept of beat BURST_LEN-1, wreqa goes to 0 at that edge.
  - After that final accept: if burst index is NUM_BURSTS-1, go to DONE; otherwise go to GAP with the gap counter set to GAP_CYCLES-1.
- GAP: wreqa=0. The gap counter decrements each cycle. At 0, go to BURST with wreqa=~hold. hold does not extend the gap.
- Data sequence:
  - Each accept loads the next value; wdata continues across bursts and is only reset by start or rstna.
  - MODE 0: next value is wdata+1, wrapping modulo 2^DW (8'hFF becomes 8'h00).
  - MODE 1: Galois LFSR with maximal-length taps from the package (8: x^8+x^6+x^5+x^4+1; 16: x^16+x^14+x^13+x^11+1; 32: x^32+x^22+x^2+x+1). The value never becomes 0.
- Write-to-visible latency: the first wreqa is visible 1 cycle after start. Back-to-back accepts give 1 word per cycle when fulla=0.
- fulla rising in the same cycle as the final beat: that beat is not accepted, and the state remains BURST until it is.
- busy = state is BURST or GAP. done = state is DONE. Both are registered.
- rstna asserted mid-run: all outputs return to reset values immediately (asynchronous). Deassertion returns to IDLE, and no write is issued without a new start.
- Total accepted writes per run = BURST_LEN*NUM_BURSTS. wr_count equals this value modulo 2^CW at done.

Decomposition:
- Package fifo_stim_pkg holds:
  - state encoding: IDLE=2'd0, BURST=2'd1, GAP=2'd2, DONE=2'd3;
  - MODE constants MODE_INC=0 and MODE_LFSR=1;
  - function lfsr_taps(DW) returning the tap mask.
- Sub-module stim_data_gen (parameters DW, MODE, SEED):
  - inputs: load_seed, advance;
  - output: the current word;
  - contains only the pattern register and next-value logic.
- The FSM and counters live in the top module.

Test Plan:
1. DW=8, BURST_LEN=4, NUM_BURSTS=2, GAP_CYCLES=2, MODE=0, SEED=1, fulla=0, start pulse -> wdata 1,2,3,4 on 4 consecutive cycles, then 2 cycles wreqa=0, then 5,6,7,8. done=1 one cycle after the last accept, wr_count=8.
2. Same configuration, fulla=1 for 3 cycles while wdata=3 -> wreqa stays 1 and wdata=3 for 3 cycles. The sequence resumes 3,4 with no skip or duplicate, and the total stays 8.
3. MODE=0, SEED=8'hFE, BURST_LEN=4, NUM_BURSTS=1 -> wdata FE,FF,00,01, wr_count=4.
4. MODE=1, DW=8, SEED=8'h01, BURST_LEN=255, NUM_BURSTS=1 -> 255 distinct nonzero words, no 0, sequence matches a reference LFSR model.
5. hold=1 for 5 cycles mid-burst -> wreqa=0 from the next edge, no accepts. After hold=0, the retained word is written first.
6. rstna pulsed low during burst 2 -> outputs 0 immediately and state IDLE. A new start replays from SEED with wr_count from 0. start during BURST is ignored.
